sq_carry_normalizer: RTL and testbench

- Consumes the redundant-coefficient result `sq_out` from the modular squaring wrapper on its `valid` pulse.
- Propagates carries serially, COEFF_PER_CYCLE coefficients per clock, and produces a normalised binary result of NUM_ELEMENTS*WORD_LEN bits plus a carry-out.
- Sits directly downstream of the wrapper, in the `clk` domain, and feeds host readback and iteration-result checking.

---
 rtl/sq_carry_normalizer.sv | 157 +++++++++++++++
 tb/tb_sq_carry_normalizer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sq_carry_normalizer.sv
// Serial carry normaliser: folds redundant squaring-unit coefficients into a binary result,
// COEFF_PER_CYCLE digits per clock, with a two-bit carry-out above the top digit.
module sq_carry_normalizer #(
   parameter int unsigned MOD_LEN               = 1024,
   parameter int unsigned WORD_LEN              = 16,
   parameter int unsigned BIT_LEN               = 17,
   parameter int unsigned REDUNDANT_ELEMENTS    = 2,
   parameter int unsigned NONREDUNDANT_ELEMENTS = MOD_LEN / WORD_LEN,
   parameter int unsigned NUM_ELEMENTS          = REDUNDANT_ELEMENTS + NONREDUNDANT_ELEMENTS,
   parameter int unsigned SQ_OUT_BITS           = NUM_ELEMENTS * WORD_LEN * 2,
   parameter int unsigned COEFF_PER_CYCLE       = 4,
   parameter int unsigned NUM_STEPS             =
      (NUM_ELEMENTS + COEFF_PER_CYCLE - 1) / COEFF_PER_CYCLE
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [SQ_OUT_BITS-1:0]           sq_out,
   input  logic                             sq_valid,
   output logic                             busy,
   output logic [NUM_ELEMENTS*WORD_LEN-1:0] result,
   output logic [1:0]                       carry_out,
   output logic                             result_valid,
   output logic                             dropped
);

   localparam int unsigned LaneW  = SQ_OUT_BITS / NUM_ELEMENTS;
   localparam int unsigned SumW   = BIT_LEN + 1;
   localparam int unsigned ResW   = NUM_ELEMENTS * WORD_LEN;
   localparam int unsigned CoeffW = NUM_ELEMENTS * BIT_LEN;
   localparam int unsigned StepW  = (NUM_STEPS > 1) ? $clog2(NUM_STEPS + 1) : 1;

   typedef enum logic [1:0] {StIdle, StReduce, StDone} state_e;

   state_e             state_q, state_d;
   logic [StepW-1:0]   step_q;
   logic [1:0]         carry_q;
   logic [CoeffW-1:0]  coeff_q;
   logic [ResW-1:0]    work_q;
   logic [ResW-1:0]    result_q;
   logic [1:0]         carry_out_q;
   logic               result_valid_q;
   logic               dropped_q;

   logic [CoeffW-1:0]  cap_coeff;
   logic [ResW-1:0]    work_d;
   logic [1:0]         step_carry;
   logic [SumW-1:0]    sum;
   logic [1:0]         c;
   int unsigned        idx;
   logic               capture;
   logic               last_step;
   logic               unused_lane_bits;

   // Lane bits above BIT_LEN carry no information and are discarded at capture.
   assign unused_lane_bits = ^sq_out;

   always_comb begin
      cap_coeff = '0;
      for (int unsigned j = 0; j < NUM_ELEMENTS; j++) begin
         cap_coeff[j*BIT_LEN +: BIT_LEN] = sq_out[j*LaneW +: BIT_LEN];
      end
   end

   // One step of the ripple: lanes past the top element leave the carry untouched.
   always_comb begin
      work_d = work_q;
      c      = carry_q;
      sum    = '0;
      idx    = 0;
      for (int unsigned k = 0; k < COEFF_PER_CYCLE; k++) begin
         idx = 32'(step_q) * COEFF_PER_CYCLE + k;
         if (idx < NUM_ELEMENTS) begin
            sum = SumW'(coeff_q[idx*BIT_LEN +: BIT_LEN]) + SumW'(c);
            work_d[idx*WORD_LEN +: WORD_LEN] = sum[WORD_LEN-1:0];
            c = 2'(sum >> WORD_LEN);
         end
      end
      step_carry = c;
   end

   assign last_step = (step_q == StepW'(NUM_STEPS - 1));

   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (sq_valid) begin
               state_d = StReduce;
               capture = 1'b1;
            end
         end
         StReduce: begin
            if (last_step) begin
               state_d = StDone;
            end
         end
         StDone: begin
            if (sq_valid) begin
               state_d = StReduce;
               capture = 1'b1;
            end else begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         step_q         <= '0;
         carry_q        <= '0;
         coeff_q        <= '0;
         work_q         <= '0;
         result_q       <= '0;
         carry_out_q    <= '0;
         result_valid_q <= 1'b0;
         dropped_q      <= 1'b0;
      end else begin
         result_valid_q <= 1'b0;
         if (sq_valid && (state_q == StReduce)) begin
            dropped_q <= 1'b1;
         end
         if (capture) begin
            coeff_q <= cap_coeff;
            carry_q <= '0;
            step_q  <= '0;
            work_q  <= '0;
         end else if (state_q == StReduce) begin
            work_q  <= work_d;
            carry_q <= step_carry;
            step_q  <= step_q + StepW'(1);
            if (last_step) begin
               result_q       <= work_d;
               carry_out_q    <= step_carry;
               result_valid_q <= 1'b1;
            end
         end
      end
   end

   assign busy         = (state_q == StReduce);
   assign result       = result_q;
   assign carry_out    = carry_out_q;
   assign result_valid = result_valid_q;
   assign dropped      = dropped_q;

endmodule

// File: tb/tb_sq_carry_normalizer.sv
// Bench for sq_carry_normalizer: fixed vectors, random vectors against a big-integer model,
// and hand sequences for dropped pulses, back-to-back starts and mid-run reset.
module tb_sq_carry_normalizer;

   localparam int NE  = 66;
   localparam int WL  = 16;
   localparam int SQW = NE * 32;
   localparam int RW  = NE * WL;
   localparam int MW  = RW + 2;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [SQW-1:0] sq_out = '0;
   logic          sq_valid = 1'b0;
   logic          busy;
   logic [RW-1:0] result;
   logic [1:0]    carry_out;
   logic          result_valid;
   logic          dropped;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [SQW-1:0] sq;
      logic [RW-1:0]  res;
      logic [1:0]     cy;
   } vec_t;

   vec_t tbl [4];

   sq_carry_normalizer dut (
      .clk          (clk),
      .reset        (reset),
      .sq_out       (sq_out),
      .sq_valid     (sq_valid),
      .busy         (busy),
      .result       (result),
      .carry_out    (carry_out),
      .result_valid (result_valid),
      .dropped      (dropped)
   );

   always #5 clk = ~clk;

   // Value of the redundant number: sum of coeff_j * 2^(16j), upper lane bits masked off.
   function automatic logic [MW-1:0] model(input logic [SQW-1:0] v);
      logic [MW-1:0] t;
      logic [MW-1:0] term;
      t = '0;
      for (int j = 0; j < NE; j++) begin
         term = MW'(v[j*32 +: 17]);
         t = t + (term << (WL * j));
      end
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic chk_res(input string name, input logic [RW-1:0] got, input logic [RW-1:0] exp);
      int bad;
      checks++;
      if (got !== exp) begin
         errors++;
         bad = -1;
         for (int j = 0; j < NE; j++) begin
            if (bad < 0 && got[j*WL +: WL] !== exp[j*WL +: WL]) bad = j;
         end
         if (bad < 0) bad = 0;
         $display("FAIL %s: digit %0d got %04h expected %04h", name, bad,
                  got[bad*WL +: WL], exp[bad*WL +: WL]);
      end
   endtask

   // Pulses sq_valid so the next rising edge is the capture edge; returns 1 ns after it.
   task automatic start(input logic [SQW-1:0] v);
      sq_out   = v;
      sq_valid = 1'b1;
      @(posedge clk);
      #1;
      sq_valid = 1'b0;
   endtask

   // Counts edges after capture until result_valid, and busy cycles seen on the way.
   task automatic wait_done(output int lat, output int bcnt);
      lat  = 0;
      bcnt = 0;
      forever begin
         if (busy) bcnt++;
         if (result_valid || lat >= 40) break;
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic run_case(input string name, input logic [SQW-1:0] v,
                           input logic [RW-1:0] eres, input logic [1:0] ecy);
      int lat;
      int bcnt;
      start(v);
      wait_done(lat, bcnt);
      chk({name, " latency"}, 32'(lat), 32'd17);
      chk({name, " busy cycles"}, 32'(bcnt), 32'd17);
      chk_res({name, " result"}, result, eres);
      chk({name, " carry_out"}, 32'(carry_out), 32'(ecy));
      @(posedge clk);
      #1;
      chk({name, " valid pulse width"}, 32'(result_valid), 32'd0);
      chk_res({name, " result hold"}, result, eres);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [SQW-1:0] s;
      logic [RW-1:0]  r;
      logic [MW-1:0]  m;
      logic [SQW-1:0] va;
      logic [SQW-1:0] vb;
      int             lat;
      int             bcnt;
      int             seen;

      #1;
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset result_valid", 32'(result_valid), 32'd0);
      chk_res("reset result", result, '0);
      chk("reset carry_out", 32'(carry_out), 32'd0);
      chk("reset dropped", 32'(dropped), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      tbl[0].sq = '0;
      tbl[0].res = '0;
      tbl[0].cy = 2'd0;

      s = '0;
      s[31:0] = 32'h0001_0000;
      r = '0;
      r[31:16] = 16'h0001;
      tbl[1].sq = s;
      tbl[1].res = r;
      tbl[1].cy = 2'd0;

      s = '0;
      r = '0;
      for (int j = 0; j < NE; j++) begin
         s[j*32 +: 32] = 32'h0001_FFFF;
         r[j*WL +: WL] = (j == 0) ? 16'hFFFF : (j == 1) ? 16'h0000 : 16'h0001;
      end
      tbl[2].sq = s;
      tbl[2].res = r;
      tbl[2].cy = 2'd2;

      s = '0;
      s[5*32 +: 32] = 32'hFFFE_0003;
      r = '0;
      r[5*WL +: WL] = 16'h0003;
      tbl[3].sq = s;
      tbl[3].res = r;
      tbl[3].cy = 2'd0;

      for (int i = 0; i < 4; i++) begin
         run_case($sformatf("vec%0d", i), tbl[i].sq, tbl[i].res, tbl[i].cy);
      end
      chk("dropped after isolated runs", 32'(dropped), 32'd0);

      for (int i = 0; i < 20; i++) begin
         for (int j = 0; j < NE; j++) begin
            s[j*32 +: 32] = (i % 4 == 0) ? ($urandom | 32'h0001_FFFF) : $urandom;
         end
         m = model(s);
         run_case($sformatf("rand%0d", i), s, m[RW-1:0], m[MW-1:RW]);
      end

      // Pulse during REDUCE is ignored, then a restart in the DONE cycle.
      va = tbl[2].sq;
      for (int j = 0; j < NE; j++) vb[j*32 +: 32] = $urandom;
      start(va);
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      sq_out   = vb;
      sq_valid = 1'b1;
      @(posedge clk);
      #1;
      sq_valid = 1'b0;
      lat = 5;
      while (!result_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("drop latency", 32'(lat), 32'd17);
      chk_res("drop first result", result, tbl[2].res);
      chk("drop carry_out", 32'(carry_out), 32'd2);
      chk("dropped set", 32'(dropped), 32'd1);
      start(vb);
      chk("restart busy", 32'(busy), 32'd1);
      wait_done(lat, bcnt);
      chk("back-to-back spacing", 32'(lat + 1), 32'd18);
      m = model(vb);
      chk_res("back-to-back result", result, m[RW-1:0]);
      chk("back-to-back carry", 32'(carry_out), 32'(m[MW-1:RW]));
      chk("dropped sticky", 32'(dropped), 32'd1);

      // Asynchronous reset mid-REDUCE.
      for (int j = 0; j < NE; j++) s[j*32 +: 32] = $urandom;
      start(s);
      repeat (8) begin
         @(posedge clk);
         #1;
      end
      #2;
      reset = 1'b1;
      #1;
      chk("mid reset busy", 32'(busy), 32'd0);
      chk("mid reset result_valid", 32'(result_valid), 32'd0);
      chk_res("mid reset result", result, '0);
      chk("mid reset carry_out", 32'(carry_out), 32'd0);
      chk("mid reset dropped", 32'(dropped), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      seen = 0;
      repeat (25) begin
         @(posedge clk);
         #1;
         if (result_valid) seen++;
      end
      chk("no pulse after reset", 32'(seen), 32'd0);
      for (int j = 0; j < NE; j++) s[j*32 +: 32] = $urandom;
      m = model(s);
      run_case("post reset", s, m[RW-1:0], m[MW-1:RW]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
